// File: rtl/mips_dcache.sv
// Direct-mapped write-back, write-allocate data cache for the MIPS MEM stage.
// Stalls the pipeline through lock during misses and full-cache flushes.
module mips_dcache #(
  parameter int NUM_LINES   = 256,
  parameter int MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic             req_is_word,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      req_rdata,
  output logic             lock,
  input  logic             flush,
  output logic             flush_done,
  output logic [31:0]      mem_addr,
  output logic [0:3][7:0]  mem_data_in,
  input  logic [0:3][7:0]  mem_data_out,
  output logic             mem_write_en
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int CW    = $clog2(MEM_LATENCY) + 1;

  typedef enum logic [2:0] {
    IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   done_q, done_d;
  logic [NUM_LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [0:3][7:0]        data_q [NUM_LINES];

  logic [IDX_W-1:0] idx, wb_idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       lane;
  logic             hit, last;
  logic             store_en, refill_en, wb_clr;
  logic [7:0]       rbyte;

  assign idx    = req_addr[IDX_W+1:2];
  assign tag    = req_addr[31:IDX_W+2];
  assign lane   = req_addr[1:0];
  assign hit    = req_valid & valid_q[idx] & (tag_q[idx] == tag);
  assign last   = (cnt_q == CW'(MEM_LATENCY - 1));
  assign wb_idx = (state_q == FLUSH_WB) ? ptr_q : idx;
  assign rbyte  = data_q[idx][lane];
  assign flush_done = done_q;

  always_comb begin
    req_rdata = '0;
    if (hit) begin
      if (req_is_word) req_rdata = data_q[idx];
      else             req_rdata = {{24{rbyte[7]}}, rbyte};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    done_d       = done_q;
    lock         = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    store_en     = 1'b0;
    refill_en    = 1'b0;
    wb_clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a finished flush is not repeated until a store dirties a line
        if (flush && !done_q) begin
          lock    = 1'b1;
          ptr_d   = '0;
          state_d = FLUSH_SCAN;
        end else if (req_valid && !hit) begin
          lock    = 1'b1;
          cnt_d   = '0;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
        end else if (hit && req_we) begin
          store_en = 1'b1;
          done_d   = 1'b0;
        end
      end
      WRITEBACK, FLUSH_WB: begin
        lock         = 1'b1;
        mem_addr     = {tag_q[wb_idx], wb_idx, 2'b00};
        mem_data_in  = data_q[wb_idx];
        mem_write_en = 1'b1;
        cnt_d        = cnt_q + CW'(1);
        if (last) begin
          wb_clr = 1'b1;
          cnt_d  = '0;
          if (state_q == WRITEBACK) begin
            state_d = REFILL;
          end else if (ptr_q == IDX_W'(NUM_LINES - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            state_d = FLUSH_SCAN;
          end
        end
      end
      REFILL: begin
        lock     = 1'b1;
        mem_addr = {req_addr[31:2], 2'b00};
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          refill_en = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      FLUSH_SCAN: begin
        lock = 1'b1;
        if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
          cnt_d   = '0;
          state_d = FLUSH_WB;
        end else if (ptr_q == IDX_W'(NUM_LINES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      if (refill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (store_en) dirty_q[idx] <= 1'b1;
      if (wb_clr) dirty_q[wb_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_en) begin
      data_q[idx] <= mem_data_out;
      tag_q[idx]  <= tag;
    end else if (store_en) begin
      if (req_is_word) data_q[idx]       <= req_wdata;
      else             data_q[idx][lane] <= req_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_mips_dcache.sv
// Directed bench for mips_dcache with 4 lines and a 4-cycle memory.
// Memory is a small preloaded array; writes are logged per cycle.
module tb_mips_dcache;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_we, req_is_word;
  logic [31:0]     req_addr, req_wdata, req_rdata;
  logic            lock, flush, flush_done;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in, mem_data_out;
  logic            mem_write_en;

  always #5 clk = ~clk;

  mips_dcache #(.NUM_LINES(4), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_is_word(req_is_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .lock(lock), .flush(flush), .flush_done(flush_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write_en(mem_write_en)
  );

  logic [31:0] mem [0:63];
  assign mem_data_out = mem[mem_addr[7:2]];

  int checks = 0;
  int failures = 0;
  int lk, we;
  logic [31:0] last_addr;
  logic [31:0] wl_addr [32];
  logic [31:0] wl_data [32];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic wd,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = v; req_we = w; req_is_word = wd;
    req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic wait_unlock();
    lk = 0; we = 0; last_addr = '0;
    for (int i = 0; i < 200 && lock; i++) begin
      lk++;
      if (mem_write_en) begin
        if (we < 32) begin
          wl_addr[we] = mem_addr;
          wl_data[we] = mem_data_in;
        end
        we++;
      end
      last_addr = mem_addr;
      @(negedge clk); #1;
    end
    if (lock) check("lock_timeout", 32'(lock), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4]  = 32'hDEADBEEF;
    mem[20] = 32'h55667788;
    mem[17] = 32'h44444444;
    mem[6]  = 32'h01020304;

    rst = 1'b1; flush = 1'b0;
    req_valid = 0; req_we = 0; req_is_word = 0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_we", 32'(mem_write_en), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_data_in, 32'd0);
    check("rst_rdata", req_rdata, 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);

    // clean load miss then hit
    drive(1, 0, 1, 32'h10, 0);
    wait_unlock();
    check("miss_lock", lk, 5);
    check("miss_we", we, 0);
    check("miss_addr", last_addr, 32'h10);
    check("miss_rdata", req_rdata, 32'hDEADBEEF);
    drive(1, 0, 1, 32'h10, 0);
    check("hit_lock", 32'(lock), 32'd0);
    check("hit_rdata", req_rdata, 32'hDEADBEEF);

    // byte store / byte loads
    drive(1, 1, 1, 32'h10, 32'h11223344);
    check("st_lock", 32'(lock), 32'd0);
    drive(1, 1, 0, 32'h13, 32'hAAAAAA80);
    check("stb_lock", 32'(lock), 32'd0);
    drive(1, 0, 1, 32'h10, 0);
    check("merge_word", req_rdata, 32'h11223380);
    drive(1, 0, 0, 32'h13, 0);
    check("ldb_13", req_rdata, 32'hFFFFFF80);
    drive(1, 0, 0, 32'h10, 0);
    check("ldb_10", req_rdata, 32'h00000011);

    // dirty eviction
    drive(1, 1, 1, 32'h10, 32'hCAFEF00D);
    drive(1, 0, 1, 32'h50, 0);
    wait_unlock();
    check("evict_lock", lk, 9);
    check("evict_we", we, 4);
    check("evict_wa0", wl_addr[0], 32'h10);
    check("evict_wd0", wl_data[0], 32'hCAFEF00D);
    check("evict_wa3", wl_addr[3], 32'h10);
    check("evict_wd3", wl_data[3], 32'hCAFEF00D);
    check("evict_raddr", last_addr, 32'h50);
    check("evict_rdata", req_rdata, 32'h55667788);

    // dirty lines at index 1 and 3, then flush
    drive(1, 1, 1, 32'h04, 32'h0000A1A1);
    wait_unlock();
    check("st4_lock", lk, 5);
    drive(1, 1, 1, 32'h0C, 32'h0000B3B3);
    wait_unlock();
    check("stC_lock", lk, 5);
    @(negedge clk);
    req_valid = 0; req_we = 0; flush = 1'b1;
    #1;
    wait_unlock();
    check("flush_lock", lk, 13);
    check("flush_we", we, 8);
    check("flush_wa0", wl_addr[0], 32'h04);
    check("flush_wd0", wl_data[0], 32'h0000A1A1);
    check("flush_wa4", wl_addr[4], 32'h0C);
    check("flush_wd7", wl_data[7], 32'h0000B3B3);
    check("flush_done", 32'(flush_done), 32'd1);
    @(negedge clk); #1;
    check("no_rescan", 32'(lock), 32'd0);
    flush = 1'b0;
    drive(1, 0, 1, 32'h44, 0);
    wait_unlock();
    check("clean_after_flush_lock", lk, 5);
    check("clean_after_flush_we", we, 0);
    check("ld44", req_rdata, 32'h44444444);
    drive(1, 1, 1, 32'h44, 32'h00000077);
    drive(0, 0, 1, 32'h0, 0);
    check("done_cleared", 32'(flush_done), 32'd0);

    // flush together with a pending load miss
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1; req_we = 0; req_is_word = 1; req_addr = 32'h18;
    #1;
    wait_unlock();
    check("fq_lock", lk, 14);
    check("fq_we", we, 4);
    check("fq_wa0", wl_addr[0], 32'h44);
    check("fq_wd0", wl_data[0], 32'h00000077);
    check("fq_raddr", last_addr, 32'h18);
    check("fq_rdata", req_rdata, 32'h01020304);
    check("fq_done", 32'(flush_done), 32'd1);
    flush = 1'b0;

    // reset during refill
    drive(1, 0, 1, 32'h20, 0);
    check("rr_lock0", 32'(lock), 32'd1);
    @(negedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 0;
    #1;
    check("rr_we", 32'(mem_write_en), 32'd0);
    check("rr_lock", 32'(lock), 32'd0);
    check("rr_done", 32'(flush_done), 32'd0);
    drive(1, 0, 1, 32'h50, 0);
    wait_unlock();
    check("rr_miss_lock", lk, 5);
    check("rr_rdata", req_rdata, 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
